// File: rtl/fc_feature_streamer.sv
// Frame buffer between the pooling stage and the FC layer: fill NBEATS beats, wait for the layer, stream them.
// Optional frame checksum built only when FC_STREAM_CHECKSUM_EN is defined.
module fc_feature_streamer #(
   parameter int DW     = 23,
   parameter int NBEATS = 121
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_ch1,
   input  logic [DW-1:0] in_ch2,
   input  logic [DW-1:0] in_ch3,
   output logic          in_ready,
   input  logic          layer_ready,
   output logic          valid_out,
   output logic [DW-1:0] relu_out1,
   output logic [DW-1:0] relu_out2,
   output logic [DW-1:0] relu_out3,
   output logic          frame_done,
   output logic [31:0]   checksum
);

   localparam int PW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int BW = 3 * DW;
   localparam logic [PW-1:0] LAST = PW'(NBEATS - 1);

   typedef enum logic [1:0] {FILL, WAIT, STREAM, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            issued_q, issued_d;
   logic            valid_q, valid_d;
   logic            wr_en, rd_en;
   logic [BW-1:0]   mem [NBEATS];
   logic [BW-1:0]   rd_data_q;
   logic [DW-1:0]   relu_lane [3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         issued_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         issued_q <= issued_d;
         valid_q  <= valid_d;
      end
   end

   // issued_q marks that the last beat has been read, so DONE lands one cycle after it is shown.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      issued_d   = issued_q;
      valid_d    = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      in_ready   = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_ptr_q == LAST) begin
                  wr_ptr_d = '0;
                  state_d  = WAIT;
               end else begin
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
            end
         end
         WAIT: begin
            if (layer_ready) begin
               state_d  = STREAM;
               rd_ptr_d = '0;
               issued_d = 1'b0;
            end
         end
         STREAM: begin
            if (issued_q) begin
               state_d = DONE;
            end else begin
               rd_en   = 1'b1;
               valid_d = 1'b1;
               if (rd_ptr_q == LAST) issued_d = 1'b1;
               else                  rd_ptr_d = rd_ptr_q + PW'(1);
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {in_ch3, in_ch2, in_ch1};
   end

   always_ff @(posedge clk) begin
      if (rd_en) rd_data_q <= mem[rd_ptr_q];
   end

   // Read register is not reset; gating by valid_q keeps idle outputs at zero.
   for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign relu_lane[gi] = valid_q ? rd_data_q[gi*DW +: DW] : '0;
   end

   assign valid_out = valid_q;
   assign relu_out1 = relu_lane[0];
   assign relu_out2 = relu_lane[1];
   assign relu_out3 = relu_lane[2];

`ifdef FC_STREAM_CHECKSUM_EN
   logic [31:0] acc_q, checksum_q, acc_sum;

   assign acc_sum = acc_q + 32'(relu_lane[0]) + 32'(relu_lane[1]) + 32'(relu_lane[2]);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         checksum_q <= '0;
      end else begin
         if (state_q == WAIT && state_d == STREAM) acc_q <= '0;
         else if (valid_q)                         acc_q <= acc_sum;
         if (valid_q && state_d == DONE)           checksum_q <= acc_sum;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_fc_feature_streamer.sv
// Table-driven frame bench for fc_feature_streamer with a per-frame reference model and random fills.
module tb_fc_feature_streamer;

   localparam int DW     = 23;
   localparam int NBEATS = 121;
`ifdef FC_STREAM_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, in_valid, layer_ready;
   logic [DW-1:0] in_ch1, in_ch2, in_ch3;
   logic          in_ready, valid_out, frame_done;
   logic [DW-1:0] relu_out1, relu_out2, relu_out3;
   logic [31:0]   checksum;

   int n_checks   = 0;
   int n_fail     = 0;
   int zero_viol  = 0;
   int overlap_viol = 0;

   logic [DW-1:0] exp_frame [NBEATS][3];
   logic [31:0]   prev_sum;

   typedef struct {
      int          pat;      // 0 ones, 1 twos, 2 ramp, 3 random
      int          gap_pct;
      int          hold;     // <0: layer_ready high before WAIT entry
      logic [31:0] spec_sum;
   } row_t;
   row_t rows [8];

   fc_feature_streamer #(.DW(DW), .NBEATS(NBEATS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_ch1(in_ch1), .in_ch2(in_ch2), .in_ch3(in_ch3),
      .in_ready(in_ready), .layer_ready(layer_ready),
      .valid_out(valid_out), .relu_out1(relu_out1), .relu_out2(relu_out2),
      .relu_out3(relu_out3), .frame_done(frame_done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid_out === 1'b0 && ({relu_out1, relu_out2, relu_out3} !== '0)) zero_viol++;
      if (valid_out === 1'b1 && in_ready === 1'b1) overlap_viol++;
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic build_frame(input int pat, output logic [31:0] sum);
      int v;
      sum = 0;
      for (int k = 0; k < NBEATS; k++) begin
         for (int c = 0; c < 3; c++) begin
            case (pat)
               0:       v = 1;
               1:       v = 2;
               2:       v = k + 1000 * c;
               default: v = int'($urandom_range(0, (1 << DW) - 1));
            endcase
            exp_frame[k][c] = DW'(v);
            sum += 32'(v);
         end
      end
   endtask

   task automatic fill(input int gap_pct);
      int ready_viol = 0;
      for (int k = 0; k < NBEATS; k++) begin
         if (int'($urandom_range(0, 99)) < gap_pct) begin
            repeat ($urandom_range(1, 3)) begin
               in_valid = 1'b0;
               in_ch1 = DW'($urandom());
               in_ch2 = DW'($urandom());
               in_ch3 = DW'($urandom());
               if (in_ready !== 1'b1) ready_viol++;
               step();
            end
         end
         in_valid = 1'b1;
         in_ch1 = exp_frame[k][0];
         in_ch2 = exp_frame[k][1];
         in_ch3 = exp_frame[k][2];
         if (in_ready !== 1'b1) ready_viol++;
         step();
      end
      in_valid = 1'b0;
      check("fill_in_ready", 96'(ready_viol), 96'(0));
   endtask

   task automatic stream_check(input int id, input int hold, input logic [31:0] exp_sum);
      int beats = 0;
      int idle_viol = 0;
      check("wait_in_ready", 96'(in_ready), 96'(0));
      check("checksum_hold", 96'(checksum), 96'(prev_sum));
      if (hold >= 0) begin
         layer_ready = 1'b0;
         repeat (hold) begin
            if (valid_out !== 1'b0 || in_ready !== 1'b0) idle_viol++;
            step();
         end
         check("wait_idle", 96'(idle_viol), 96'(0));
         layer_ready = 1'b1;
      end
      step();
      check("stream_latency", 96'(valid_out), 96'(0));
      step();
      while (valid_out === 1'b1 && beats < NBEATS + 4) begin
         if (beats < NBEATS)
            check("beat", 96'({relu_out3, relu_out2, relu_out1}),
                  96'({exp_frame[beats][2], exp_frame[beats][1], exp_frame[beats][0]}));
         beats++;
         step();
      end
      check("beat_count", 96'(beats), 96'(NBEATS));
      check("frame_done", 96'(frame_done), 96'(1));
      check("checksum", 96'(checksum), 96'(exp_sum));
      $display("frame %0d: beats=%0d frame_done=%0b checksum=%0d expected=%0d",
               id, beats, frame_done, checksum, exp_sum);
      prev_sum = exp_sum;
      step();
      check("done_width", 96'(frame_done), 96'(0));
      check("fill_reopen", 96'(in_ready), 96'(1));
   endtask

   initial begin
      logic [31:0] msum, esum;
      int fd_viol;

      rows[0] = '{0, 0,  -1, 32'd363};
      rows[1] = '{2, 0,   3, 32'd384780};
      rows[2] = '{2, 50,  0, 32'd384780};
      rows[3] = '{0, 0, 500, 32'd363};
      rows[4] = '{3, 50, -1, 32'd0};
      rows[5] = '{3, 0,   2, 32'd0};
      rows[6] = '{0, 0,  -1, 32'd363};
      rows[7] = '{1, 0,  -1, 32'd726};

      rst = 1'b1; in_valid = 1'b0; layer_ready = 1'b0;
      in_ch1 = '0; in_ch2 = '0; in_ch3 = '0;
      prev_sum = 32'd0;
      step();
      step();
      rst = 1'b0;
      check("rst_valid_out", 96'(valid_out), 96'(0));
      check("rst_relu", 96'({relu_out3, relu_out2, relu_out1}), 96'(0));
      check("rst_frame_done", 96'(frame_done), 96'(0));
      check("rst_checksum", 96'(checksum), 96'(0));
      check("rst_in_ready", 96'(in_ready), 96'(1));

      for (int i = 0; i < 8; i++) begin
         layer_ready = (rows[i].hold < 0);
         build_frame(rows[i].pat, msum);
         esum = (rows[i].pat == 3) ? msum : rows[i].spec_sum;
         fill(rows[i].gap_pct);
         stream_check(i, rows[i].hold, CS_EN ? esum : 32'd0);
      end

      // Reset in the middle of a stream, then a clean refill.
      layer_ready = 1'b1;
      build_frame(0, msum);
      fill(0);
      step();
      step();
      repeat (60) step();
      check("pre_reset_streaming", 96'(valid_out), 96'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid_out", 96'(valid_out), 96'(0));
      check("midrst_frame_done", 96'(frame_done), 96'(0));
      check("midrst_in_ready", 96'(in_ready), 96'(1));
      check("midrst_checksum", 96'(checksum), 96'(0));
      fd_viol = 0;
      repeat (5) begin
         if (frame_done !== 1'b0 || valid_out !== 1'b0) fd_viol++;
         step();
      end
      check("midrst_quiet", 96'(fd_viol), 96'(0));
      prev_sum = 32'd0;
      build_frame(0, msum);
      fill(0);
      stream_check(8, -1, CS_EN ? 32'd363 : 32'd0);

      check("relu_zero_when_idle", 96'(zero_viol), 96'(0));
      check("no_ready_while_streaming", 96'(overlap_viol), 96'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_feature_streamer.md
FC_FEATURE_STREAMER -- requirements
Module: fc_feature_streamer

Interface
REQ-001 Parameter: DW, default 23, width of each ReLU feature value.
REQ-002 Parameter: NBEATS, default 121, beats per frame; each beat carries one value per channel for 3 channels, so a frame holds 363 features.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream pooling beat valid.
REQ-006 in_ch1, in_ch2, in_ch3  input  DW each  upstream feature values, channels 1-3.
REQ-007 in_ready  output  1  streamer accepts an upstream beat this cycle.
REQ-008 layer_ready  input  1  downstream FC layer idle and able to take a full frame.
REQ-009 valid_out  output  1  drives the FC layer valid_in.
REQ-010 relu_out1, relu_out2, relu_out3  output  DW each  feature values to the FC layer.
REQ-011 frame_done  output  1  one-cycle pulse after the last beat of a frame.
REQ-012 checksum  output  32  sum of the last streamed frame.

Function
REQ-013 FSM states: FILL, WAIT, STREAM, DONE.
REQ-014 The frame buffer SHALL be NBEATS x (3*DW), with write pointer wr_ptr and read pointer rd_ptr.
REQ-015 FILL: in_ready=1; on in_valid&&in_ready, write the beat at wr_ptr and increment wr_ptr; in_valid gaps are allowed and write nothing.
REQ-016 FILL->WAIT on the edge that accepts beat NBEATS-1; wr_ptr then clears to 0.
REQ-017 WAIT: in_ready=0; on an edge with layer_ready=1, go to STREAM with rd_ptr=0.
REQ-018 STREAM: buffer reads are registered; if STREAM is entered at edge N, valid_out SHALL be 1 for exactly NBEATS consecutive cycles following edges N+1..N+NBEATS, with no gaps.
REQ-019 During those cycles, beat k SHALL appear on relu_out1..3 in write order.
REQ-020 STREAM ignores layer_ready and in_valid (the FC layer has no backpressure); in_ready=0.
REQ-021 After the last beat, the FSM enters DONE for one cycle: frame_done=1, valid_out=0; then FILL.
REQ-022 relu_out1..3 SHALL be 0 whenever valid_out=0.
REQ-023 layer_ready=1 already present on WAIT entry: STREAM starts on the next edge; minimum WAIT dwell is 1 cycle.
REQ-024 Pointers SHALL never exceed NBEATS-1; no wrap-around within a frame.
REQ-025 Back-to-back frames: FILL reopens the cycle after DONE; the new frame's writes do not corrupt a frame being streamed.

Reset
REQ-026 rst=1 at any edge: state->FILL, wr_ptr=rd_ptr=0, and in effect on the following cycle valid_out=0, relu_out1..3=0, frame_done=0, checksum=0, in_ready=1.
REQ-027 Reset mid-STREAM or mid-FILL SHALL discard the partial frame; buffer contents need not be cleared.

Configuration
REQ-028 Macro FC_STREAM_CHECKSUM_EN.
- Defined: checksum accumulates the unsigned sum mod 2^32 of all 3*NBEATS values streamed.
- The accumulator clears on STREAM entry.
- checksum updates in the DONE cycle and holds until the next DONE or reset.
REQ-029 Macro not defined: checksum is tied to 0, no accumulator logic is built, and all other behaviour is identical.

Verification
REQ-030 All-ones frame: fill 121 beats with every value 1, then raise layer_ready -> exactly 121 valid_out cycles with all outputs 1, one frame_done pulse, checksum=363 (macro defined) or 0 (not defined).
REQ-031 Ramp frame: beat k has ch1=k, ch2=k+1000, ch3=k+2000 -> outputs in order k=0..120; checksum=3*7260+121*3000=384780.
REQ-032 Hold layer_ready=0 after the fill -> valid_out stays 0 and in_ready=0 for 500 cycles; raise layer_ready -> streaming begins exactly 1 cycle later.
REQ-033 Random in_valid gaps (~50% duty) during fill -> streamed output is identical to the gap-free case.
REQ-034 Assert rst at stream beat 60 -> valid_out=0 the next cycle, no frame_done pulse; refilling with all-ones then yields a clean 121-beat frame.
REQ-035 Two back-to-back frames (all-ones, then all-twos) -> two separate 121-beat bursts in order; checksums 363 then 726.
